// File: rtl/pulse_train_arbiter_if.sv
// Request fields and burst status shared between the two requesters and the pulse-train arbiter.
// Requesters drive req/high/low/cnt as levels; the arbiter returns one-cycle gnt/done pulses.
interface pulse_train_arbiter_if #(
    parameter int WIDTH_BITS = 4,
    parameter int COUNT_BITS = 4
);
    logic                  req0;
    logic [WIDTH_BITS-1:0] high0;
    logic [WIDTH_BITS-1:0] low0;
    logic [COUNT_BITS-1:0] cnt0;
    logic                  req1;
    logic [WIDTH_BITS-1:0] high1;
    logic [WIDTH_BITS-1:0] low1;
    logic [COUNT_BITS-1:0] cnt1;
    logic [1:0]            gnt;
    logic [1:0]            done;
    logic                  owner;
    logic                  busy;
    logic                  signal;

    modport master (
        output req0, high0, low0, cnt0,
        output req1, high1, low1, cnt1,
        input  gnt, done, owner, busy, signal
    );

    modport slave (
        input  req0, high0, low0, cnt0,
        input  req1, high1, low1, cnt1,
        output gnt, done, owner, busy, signal
    );
endinterface

// File: rtl/pulse_train_arbiter.sv
// Round-robin shares one registered pulse-train line between two requesters; signal rises on the grant edge.
// Requests are levels sampled only in IDLE; anything arriving mid-burst waits for the next IDLE cycle.
module pulse_train_arbiter #(
    parameter int WIDTH_BITS = 4,
    parameter int COUNT_BITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    pulse_train_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

    state_t                state_q, state_d;
    logic [WIDTH_BITS-1:0] h_q, h_d, l_q, l_d, ph_q, ph_d;
    logic [COUNT_BITS-1:0] n_q, n_d, pc_q, pc_d;
    logic                  owner_q, owner_d, rr_last_q, rr_last_d;
    logic [1:0]            gnt_q, gnt_d, done_q, done_d;
    logic                  busy_q, busy_d, signal_q, signal_d;
    logic                  win;

    // A zero field still yields one cycle / one pulse.
    function automatic logic [WIDTH_BITS-1:0] nz_w(input logic [WIDTH_BITS-1:0] v);
        return (v == '0) ? WIDTH_BITS'(1) : v;
    endfunction

    function automatic logic [COUNT_BITS-1:0] nz_c(input logic [COUNT_BITS-1:0] v);
        return (v == '0) ? COUNT_BITS'(1) : v;
    endfunction

    assign win = (bus.req0 & bus.req1) ? ~rr_last_q : bus.req1;

    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        l_d       = l_q;
        n_d       = n_q;
        ph_d      = ph_q;
        pc_d      = pc_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        gnt_d     = 2'b00;
        done_d    = 2'b00;
        busy_d    = busy_q;
        signal_d  = signal_q;
        case (state_q)
            IDLE: begin
                busy_d   = 1'b0;
                signal_d = 1'b0;
                if (bus.req0 | bus.req1) begin
                    h_d       = nz_w(win ? bus.high1 : bus.high0);
                    l_d       = nz_w(win ? bus.low1  : bus.low0);
                    n_d       = nz_c(win ? bus.cnt1  : bus.cnt0);
                    owner_d   = win;
                    rr_last_d = win;
                    gnt_d     = win ? 2'b10 : 2'b01;
                    busy_d    = 1'b1;
                    signal_d  = 1'b1;
                    ph_d      = WIDTH_BITS'(1);
                    pc_d      = COUNT_BITS'(1);
                    state_d   = HIGH;
                end
            end
            HIGH: begin
                // Counters run 1..limit so an all-ones field never wraps.
                if (ph_q == h_q) begin
                    state_d  = LOW;
                    signal_d = 1'b0;
                    ph_d     = WIDTH_BITS'(1);
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            LOW: begin
                if (ph_q == l_q) begin
                    ph_d = WIDTH_BITS'(1);
                    if (pc_q == n_q) begin
                        state_d = DONE;
                        done_d  = owner_q ? 2'b10 : 2'b01;
                    end else begin
                        pc_d     = pc_q + 1'b1;
                        state_d  = HIGH;
                        signal_d = 1'b1;
                    end
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            DONE: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                signal_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            h_q       <= WIDTH_BITS'(1);
            l_q       <= WIDTH_BITS'(1);
            n_q       <= COUNT_BITS'(1);
            ph_q      <= WIDTH_BITS'(1);
            pc_q      <= COUNT_BITS'(1);
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            busy_q    <= 1'b0;
            signal_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            l_q       <= l_d;
            n_q       <= n_d;
            ph_q      <= ph_d;
            pc_q      <= pc_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            signal_q  <= signal_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.done   = done_q;
    assign bus.owner  = owner_q;
    assign bus.busy   = busy_q;
    assign bus.signal = signal_q;
endmodule
